count_sched: RTL and testbench



---
 rtl/count_sched.sv | 145 ++++++++++++++
 tb/tb_count_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sched.sv
// count_sched -- round-robin owner of one shared WIDTH-bit interval counter.
//
// Requesters raise req[i] with a cycle count on len[i*WIDTH +: WIDTH]. The
// block grants one requester at a time, runs the shared counter for exactly
// len increments (len==0 means 2^WIDTH), pulses done[i] for one cycle, and
// then returns to arbitration. Each job costs L + 3 cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   req    [NREQ]        request level per requester, held until done
//   len    [NREQ*WIDTH]  requested cycle counts, sampled only in LOAD
//   gnt    [NREQ]        one-hot grant, LOAD through DONE inclusive
//   busy                 counter owned (OR of gnt, registered)
//   done   [NREQ]        one-hot, one-cycle completion pulse
//   cnt    [WIDTH]       current counter value, held after a job ends
//   check                sticky carry, set when cnt wraps all-ones -> 0
//
// Optional build macro COUNT_SCHED_ABORT_EN: a requester that drops req
// during RUN aborts its job (no done pulse, cnt/check keep partial values,
// pointer advances as if it completed). Undefined: req drops are ignored.

module count_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      cnt,
  output logic                  check
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    sel, ptr, win, idx;
  logic             win_vld;
  logic [WIDTH-1:0] target, len_sel;
  logic [WIDTH:0]   sum;
  logic             last, abort;

  // Round-robin search starting one past the last completed owner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (sel == SW'(i)) len_sel = len[i*WIDTH +: WIDTH];
  end

  // WIDTH+1-bit increment; the top bit is the wrap carry.
  assign sum  = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
  // Modular compare makes target==0 terminate after 2^WIDTH increments.
  assign last = (sum[WIDTH-1:0] == target);

`ifdef COUNT_SCHED_ABORT_EN
  logic req_sel;
  always_comb begin
    req_sel = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (sel == SW'(i)) req_sel = req[i];
  end
  assign abort = !req_sel;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      ptr    <= SW'(NREQ - 1);
      target <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= '0;
      cnt    <= '0;
      check  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      case (state)
        IDLE: if (win_vld) begin
          sel  <= win;
          gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << win;
          busy <= 1'b1;
        end
        LOAD: begin
          target <= len_sel;
          cnt    <= '0;
          check  <= 1'b0;
        end
        RUN: begin
          if (abort) begin
            gnt  <= '0;
            busy <= 1'b0;
            ptr  <= sel;
          end else begin
            cnt   <= sum[WIDTH-1:0];
            check <= check | sum[WIDTH];
            // gnt is already the one-hot of sel.
            if (last) done <= gnt;
          end
        end
        DONE: begin
          gnt  <= '0;
          busy <= 1'b0;
          ptr  <= sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched (NREQ=4, WIDTH=8). Inputs change 1 time
// unit after a rising edge; outputs are read at that same point, so the
// value seen after the k-th edge since a request was raised is cycle T+k.

module tb_count_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] len = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      cnt;
  logic                  check;

  int nvec = 0;
  int nerr = 0;

  count_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len),
    .gnt(gnt), .busy(busy), .done(done), .cnt(cnt), .check(check)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req   = '0;
    tick;
    tick;
    nvec++;
    if ({gnt, busy, done} !== '0) begin
      nerr++;
      $display("FAIL reset_ctl: gnt=%b busy=%b done=%b, want 0", gnt, busy, done);
    end
    nvec++;
    if ({cnt, check} !== '0) begin
      nerr++;
      $display("FAIL reset_cnt: cnt=%0d check=%b, want 0", cnt, check);
    end
    reset = 1'b1;
  endtask

  task automatic test_single;
    int gcyc = 0, dk = -1, dn = 0, dcnt = -1;
    logic dchk = 1'bx;
    logic bad = 1'b0;
    len[0*WIDTH +: WIDTH] = 8'd5;
    req = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (k == 1) begin
        nvec++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
          nerr++;
          $display("FAIL single_load: gnt=%b busy=%b, want 0001/1", gnt, busy);
        end
      end
      if (gnt !== 4'b0000 && gnt !== 4'b0001) bad = 1'b1;
      if (busy !== (gnt != 0)) bad = 1'b1;
      if (gnt != 0) gcyc++;
      if (done != 0) begin
        dn++;
        if (done !== 4'b0001) bad = 1'b1;
        if (dk < 0) begin
          dk = k; dcnt = int'(cnt); dchk = check;
          req = '0;
        end
      end
    end
    nvec++;
    if (gcyc != 7) begin nerr++; $display("FAIL single_gnt_len: got %0d cycles, want 7", gcyc); end
    nvec++;
    if (dk != 7 || dn != 1) begin
      nerr++; $display("FAIL single_done: at T+%0d count %0d, want T+7 count 1", dk, dn);
    end
    nvec++;
    if (dcnt != 5 || dchk !== 1'b0) begin
      nerr++; $display("FAIL single_result: cnt=%0d check=%b, want 5/0", dcnt, dchk);
    end
    nvec++;
    if (cnt !== 8'd5 || check !== 1'b0) begin
      nerr++; $display("FAIL single_hold: cnt=%0d check=%b, want 5/0", cnt, check);
    end
    nvec++;
    if (bad) begin nerr++; $display("FAIL single_shape: gnt/busy/done shape got bad, want clean"); end
  endtask

  task automatic test_wrap;
    int gcyc = 0, dk = -1, dn = 0, rk = -1, rcnt = -1, dcnt = -1;
    logic dchk = 1'bx;
    len[2*WIDTH +: WIDTH] = 8'd0;
    req = 4'b0100;
    for (int k = 1; k <= 300; k++) begin
      tick;
      if (gnt == 4'b0100) gcyc++;
      if (check === 1'b1 && rk < 0) begin rk = k; rcnt = int'(cnt); end
      if (done != 0) begin
        dn++;
        if (dk < 0) begin
          dk = k; dcnt = int'(cnt); dchk = check;
          req = '0;
        end
      end
    end
    nvec++;
    if (gcyc != 258) begin nerr++; $display("FAIL wrap_gnt_len: got %0d, want 258", gcyc); end
    nvec++;
    if (dk != 258 || dn != 1) begin
      nerr++; $display("FAIL wrap_done: at T+%0d count %0d, want T+258 count 1", dk, dn);
    end
    nvec++;
    if (rk != 258 || rcnt != 0) begin
      nerr++; $display("FAIL wrap_check_rise: at T+%0d cnt=%0d, want T+258 cnt=0", rk, rcnt);
    end
    nvec++;
    if (dcnt != 0 || dchk !== 1'b1) begin
      nerr++; $display("FAIL wrap_result: cnt=%0d check=%b, want 0/1", dcnt, dchk);
    end
  endtask

  task automatic test_round_robin;
    int order[5];
    int dt[5];
    int ng = 0, nd = 0;
    logic [NREQ-1:0] pg = '0;
    logic ovl = 1'b0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    tick;
    reset = 1'b1;
    len = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if ($countones(gnt) > 1) ovl = 1'b1;
      if (gnt != 0 && pg == 0 && ng < 5) begin
        for (int b = 0; b < NREQ; b++) if (gnt[b]) order[ng] = b;
        ng++;
      end
      pg = gnt;
      if (done != 0 && nd < 5) begin
        dt[nd] = k;
        nd++;
        if (nd == 5) req = '0;
      end
    end
    nvec++;
    if (ng != 5 || nd != 5) begin
      nerr++; $display("FAIL rr_count: grants=%0d dones=%0d, want 5/5", ng, nd);
    end else begin
      for (int i = 0; i < 5; i++) begin
        nvec++;
        if (order[i] != exp_order[i]) begin
          nerr++; $display("FAIL rr_order[%0d]: got %0d, want %0d", i, order[i], exp_order[i]);
        end
      end
      nvec++;
      if (dt[0] != 3) begin nerr++; $display("FAIL rr_first_done: got T+%0d, want T+3", dt[0]); end
      for (int i = 1; i < 5; i++) begin
        nvec++;
        if (dt[i] - dt[i-1] != 4) begin
          nerr++; $display("FAIL rr_spacing[%0d]: got %0d, want 4", i, dt[i] - dt[i-1]);
        end
      end
    end
    nvec++;
    if (ovl) begin nerr++; $display("FAIL rr_overlap: got multi-bit gnt, want one-hot"); end
  endtask

  task automatic test_mid_reset;
    logic sawdone = 1'b0;
    int dk = -1;
    len[1*WIDTH +: WIDTH] = 8'd20;
    req = 4'b0010;
    for (int k = 1; k <= 11; k++) begin
      tick;
      if (done != 0) sawdone = 1'b1;
    end
    nvec++;
    if (gnt !== 4'b0010 || cnt !== 8'd9) begin
      nerr++; $display("FAIL midrst_run: gnt=%b cnt=%0d, want 0010/9", gnt, cnt);
    end
    reset = 1'b0;
    tick;
    nvec++;
    if ({gnt, busy, done, cnt, check} !== '0) begin
      nerr++;
      $display("FAIL midrst_clear: gnt=%b busy=%b done=%b cnt=%0d check=%b, want 0",
               gnt, busy, done, cnt, check);
    end
    reset = 1'b1;
    len[0*WIDTH +: WIDTH] = 8'd2;
    req = 4'b0011;
    tick;
    if (done != 0) sawdone = 1'b1;
    nvec++;
    if (gnt !== 4'b0001) begin
      nerr++; $display("FAIL midrst_rearb: gnt=%b, want 0001", gnt);
    end
    for (int k = 2; k <= 20; k++) begin
      tick;
      if (done == 4'b0010) sawdone = 1'b1;
      if (done == 4'b0001 && dk < 0) begin dk = k; req = '0; end
    end
    nvec++;
    if (sawdone) begin nerr++; $display("FAIL midrst_no_done1: got done[1], want none"); end
    nvec++;
    if (dk != 4) begin nerr++; $display("FAIL midrst_job0: done at T+%0d, want T+4", dk); end
  endtask

  task automatic test_abort;
    len[3*WIDTH +: WIDTH] = 8'd10;
    req = 4'b1000;
    for (int k = 1; k <= 5; k++) tick;
    nvec++;
    if (cnt !== 8'd3 || gnt !== 4'b1000) begin
      nerr++; $display("FAIL abort_pre: cnt=%0d gnt=%b, want 3/1000", cnt, gnt);
    end
    req = '0;
`ifdef COUNT_SCHED_ABORT_EN
    begin
      logic sawdone = 1'b0;
      tick;
      nvec++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || cnt !== 8'd3) begin
        nerr++; $display("FAIL abort_stop: gnt=%b busy=%b cnt=%0d, want 0000/0/3", gnt, busy, cnt);
      end
      for (int k = 0; k < 15; k++) begin
        tick;
        if (done != 0) sawdone = 1'b1;
      end
      nvec++;
      if (sawdone || cnt !== 8'd3) begin
        nerr++; $display("FAIL abort_quiet: done seen=%b cnt=%0d, want 0/3", sawdone, cnt);
      end
    end
`else
    begin
      int dk = -1, dcnt = -1;
      logic [NREQ-1:0] dv = '0;
      for (int k = 6; k <= 30; k++) begin
        tick;
        if (done != 0 && dk < 0) begin dk = k; dcnt = int'(cnt); dv = done; end
      end
      nvec++;
      if (dk != 12 || dv !== 4'b1000) begin
        nerr++; $display("FAIL noabort_done: at T+%0d done=%b, want T+12 1000", dk, dv);
      end
      nvec++;
      if (dcnt != 10) begin nerr++; $display("FAIL noabort_cnt: got %0d, want 10", dcnt); end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_round_robin;
    test_mid_reset;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
